// File: rtl/pong_game_sequencer.sv
// pong_game_sequencer
// Match-level controller for the pong ball/paddle engine. It divides clk into
// game ticks and issues a one-cycle step pulse to the engine during play. It
// also sequences the match phases, keeps both scores, and tracks the serve
// direction and the winner.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ena          design enable; when low, all state freezes and step is 0
//   start        start button (level); only its rising edge acts
//   pause        level; when high, step is held low in PLAY
//   miss_left    engine pulse: ball passed the left edge (right player scores)
//   miss_right   engine pulse: ball passed the right edge (left player scores)
//   step         one-cycle engine update enable, at most once per tick
//   ball_reset   engine holds the ball at centre while this is high
//   serve_dir    0 = serve toward left, 1 = serve toward right
//   score_left   left player score
//   score_right  right player score
//   state        FSM phase: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4
//   winner       0 = left, 1 = right; meaningful only in GAME_OVER
module pong_game_sequencer #(
  parameter int TICK_DIV    = 16,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 4,
  parameter int POINT_DELAY = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       pause,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       step,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [2:0] state,
  output logic       winner
);

  localparam int MAX_DELAY = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
  localparam int DW        = $clog2(MAX_DELAY) + 1;
  localparam int PW        = $clog2(TICK_DIV);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SERVE     = 3'd1;
  localparam logic [2:0] S_PLAY      = 3'd2;
  localparam logic [2:0] S_POINT     = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] SERVE_LAST = DW'(SERVE_DELAY - 1);
  localparam logic [DW-1:0] POINT_LAST = DW'(POINT_DELAY - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  logic [2:0]    state_q;
  logic [PW-1:0] presc_q;
  logic [DW-1:0] dcnt_q;
  logic          start_q;
  logic [3:0]    score_l_q;
  logic [3:0]    score_r_q;
  logic          serve_dir_q;
  logic          winner_q;

  logic          tick;
  logic          start_rise;
  logic [3:0]    score_l_inc;
  logic [3:0]    score_r_inc;

  assign tick        = ena && (presc_q == PRESC_LAST);
  assign start_rise  = start && !start_q;
  assign score_l_inc = score_l_q + 4'd1;
  assign score_r_inc = score_r_q + 4'd1;

  assign step        = tick && (state_q == S_PLAY) && !pause;
  assign ball_reset  = (state_q == S_IDLE) || (state_q == S_SERVE) || (state_q == S_POINT);
  assign serve_dir   = serve_dir_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign state       = state_q;
  assign winner      = winner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      dcnt_q      <= '0;
      start_q     <= 1'b1;  // a start held through reset must not count as an edge
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      serve_dir_q <= 1'b1;
      winner_q    <= 1'b0;
    end else if (ena) begin
      presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      start_q <= start;

      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_q <= S_SERVE;
            dcnt_q  <= '0;
          end
        end

        S_SERVE: begin
          if (tick) begin
            if (dcnt_q == SERVE_LAST) begin
              state_q <= S_PLAY;
              dcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
        end

        // Misses are sampled every enabled cycle, not just on ticks, so a
        // one-cycle engine pulse is never lost. A simultaneous double miss
        // is treated as a replay with no score change.
        S_PLAY: begin
          if (miss_left && miss_right) begin
            state_q <= S_SERVE;
            dcnt_q  <= '0;
          end else if (miss_left) begin
            score_r_q   <= score_r_inc;
            serve_dir_q <= 1'b0;
            dcnt_q      <= '0;
            if (score_r_inc == WIN) begin
              state_q  <= S_GAME_OVER;
              winner_q <= 1'b1;
            end else begin
              state_q <= S_POINT;
            end
          end else if (miss_right) begin
            score_l_q   <= score_l_inc;
            serve_dir_q <= 1'b1;
            dcnt_q      <= '0;
            if (score_l_inc == WIN) begin
              state_q  <= S_GAME_OVER;
              winner_q <= 1'b0;
            end else begin
              state_q <= S_POINT;
            end
          end
        end

        S_POINT: begin
          if (tick) begin
            if (dcnt_q == POINT_LAST) begin
              state_q <= S_SERVE;
              dcnt_q  <= '0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
        end

        S_GAME_OVER: begin
          if (start_rise) begin
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            serve_dir_q <= 1'b1;
            winner_q    <= 1'b0;
            dcnt_q      <= '0;
            state_q     <= S_SERVE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
